pn_code_gen: RTL and testbench
==============================

// Module: pn_code_gen
// PURPOSE
//  Upstream code source for the correlator bank. Generates a maximal-length PN (LFSR) chip
//  sequence at a programmable chip rate, and drives NUM_CH delayed copies as the per-correlator
//  code inputs. Emits an epoch pulse once per sequence period so the capture window can be
//  aligned. Configured over the same 8-bit cs/we/oe register bus as the dispatcher.
// PARAMETERS
//  LFSR_W    10      LFSR width; sequence period = 2^LFSR_W-1 chips
//  TAPS      10'h240 feedback mask (bits 9,6: x^10+x^7+1)
//  DIV_W     16      chip-rate divider width
//  DIV_RST   3       divider reset value (chip every DIV+1 clocks)
//  NUM_CH    2       number of code outputs (chip-delayed copies)
// PORTS
//  clk       in  1       system clock
//  rst       in  1       asynchronous reset, active-low
//  addr_in   in  8       register address
//  data_in   in  8       write data
//  cs        in  1       bus select
//  we        in  1       write enable (qualified by cs)
//  oe        in  1       read enable (qualified by cs)
//  data_out  out 8       read data
//  rdy       out 1       one-cycle access acknowledge
//  code      out NUM_CH  code[k] = prompt chip delayed k chips
//  chip_stb  out 1       one-cycle pulse on each chip advance
//  epoch     out 1       one-cycle pulse when LFSR returns to seed
// BEHAVIOUR
//  Reset (rst=0, async): lfsr=all-ones, seed=all-ones, div=DIV_RST, div_ctr=0, enable=0,
//   hist=0; outputs code=0, chip_stb=0, epoch=0, data_out=0, rdy=0.
//  Registers: 0x00 DIV[7:0], 0x01 DIV[15:8], 0x02 SEED[7:0], 0x03 SEED[LFSR_W-1:8],
//   0x04 CTRL {bit1 restart (self-clearing, reads 0), bit0 enable}, 0x05 STATUS
//   {bit0 enable}. Other addresses: writes ignored, reads 0.
//  Bus: write takes effect on the clock edge with cs&we. On cs&oe, data_out is registered
//   next cycle. rdy pulses high for 1 cycle the cycle after any cs&(we|oe).
//  Divider: when enable=1, div_ctr increments each clk. When div_ctr>=div, chip_stb=1
//   (registered) and div_ctr<=0. Using >= means lowering DIV mid-run never wraps the full
//   2^DIV_W. DIV=0 gives a chip every clock.
//  LFSR (Fibonacci) advances on each chip_stb: lfsr<={lfsr[W-2:0], ^(lfsr&TAPS)}.
//   Prompt chip = lfsr[W-1].
//  hist[NUM_CH-1:0] shifts in the prompt chip on each strobe; code=hist. Outputs hold
//   between strobes.
//  epoch: asserted with the strobe whose advance makes the new lfsr equal to the seed.
//   Period = 2^W-1 chips.
//  Seed 0 (lock-up state): the register reads back 0, but all-ones is loaded into lfsr.
//  Restart (write CTRL bit1=1): next edge lfsr<=seed, div_ctr<=0, hist<=0, no strobe, no
//   epoch. It wins over a coincident chip_stb. The enable bit is written from the same data
//   byte.
//  enable=0: div_ctr, lfsr and hist are frozen; chip_stb=epoch=0. Re-enable resumes without
//   a phase jump.
//  SEED writes affect only a later restart, never the running lfsr.
// STRUCTURE
//  Shared package: register address constants, CTRL bit positions, default TAPS per LFSR_W.
//  One natural sub-module, pn_lfsr (seed load, advance, epoch compare). Bus regs, divider
//   and hist stay in the top level.
// TESTING
//  1 Hold reset low -> code=0, chip_stb=0, epoch=0, rdy=0, STATUS read=0x00. Assert reset
//    mid-run -> all outputs clear asynchronously.
//  2 DIV=0, SEED=0x3FF, restart+enable -> chip_stb every clk. Prompt bits match the model:
//    first chips 1,1,1,1,1,1,1,1,1,1,0. epoch after exactly 1023 strobes.
//  3 DIV=3 -> chip_stb period 4 clks, epoch period 4092 clks. code[1] equals code[0]
//    delayed by 4 clks.
//  4 Write SEED=0x000, restart -> SEED reads 0x00/0x00, lfsr=0x3FF, sequence identical to
//    test 2.
//  5 Issue restart on the same clk as a due strobe -> lfsr=seed, div_ctr=0, no chip_stb or
//    epoch that cycle.
//  6 Run DIV=0x0100, with div_ctr=0x80 write DIV=0x0010 -> strobe next clk, then period 17.
//    Disable for 50 clks -> outputs frozen, phase continuous after re-enable.

Source files
------------

// File: rtl/pn_code_gen_pkg.sv
// rtl/pn_code_gen_pkg.sv - register map, control bit positions and default LFSR taps for pn_code_gen
package pn_code_gen_pkg;

  // Register addresses on the 8-bit cs/we/oe bus
  localparam logic [7:0] ADDR_DIV_LO  = 8'h00;
  localparam logic [7:0] ADDR_DIV_HI  = 8'h01;
  localparam logic [7:0] ADDR_SEED_LO = 8'h02;
  localparam logic [7:0] ADDR_SEED_HI = 8'h03;
  localparam logic [7:0] ADDR_CTRL    = 8'h04;
  localparam logic [7:0] ADDR_STATUS  = 8'h05;

  // CTRL / STATUS bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_RESTART  = 1;
  localparam int STATUS_ENABLE = 0;

  // Feedback masks for a left-shifting Fibonacci LFSR whose feedback enters bit 0.
  // Every entry yields a maximal-length (2^w-1) sequence.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0240;
    endcase
  endfunction

endpackage

// File: rtl/pn_lfsr.sv
// rtl/pn_lfsr.sv - Fibonacci LFSR with seed load, chip advance and return-to-seed detect
module pn_lfsr import pn_code_gen_pkg::*; #(
  parameter int           W    = 10,
  parameter logic [W-1:0] TAPS = W'(default_taps(W))
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] seed,
  output logic         prompt,
  output logic         wrap
);

  logic [W-1:0] state;
  logic [W-1:0] start;
  logic [W-1:0] next_state;
  logic [W-1:0] load_val;

  // Next state and the effective seed; a zero seed would lock the LFSR, so all-ones is used instead
  always_comb begin
    next_state = {state[W-2:0], ^(state & TAPS)};
    load_val   = (seed == '0) ? '1 : seed;
  end

  assign prompt = state[W-1];
  // Compared against the seed captured at the last load, so later SEED writes cannot move the epoch
  assign wrap   = (next_state == start);

  // State register: load has priority over a coincident advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '1;
      start <= '1;
    end else if (load) begin
      state <= load_val;
      start <= load_val;
    end else if (advance) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/pn_code_gen.sv
// rtl/pn_code_gen.sv - programmable-rate PN chip generator with delayed code taps and epoch pulse
module pn_code_gen import pn_code_gen_pkg::*; #(
  parameter int                LFSR_W  = 10,
  parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(default_taps(LFSR_W)),
  parameter int                DIV_W   = 16,
  parameter int                DIV_RST = 3,
  parameter int                NUM_CH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr_in,
  input  logic [7:0]        data_in,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  output logic [7:0]        data_out,
  output logic              rdy,
  output logic [NUM_CH-1:0] code,
  output logic              chip_stb,
  output logic              epoch
);

  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_ctr;
  logic [LFSR_W-1:0] seed;
  logic              enable;
  logic [NUM_CH-1:0] hist;

  // Byte-addressable views of DIV and SEED (both fit in two bytes)
  logic [15:0] div_wide;
  logic [15:0] seed_wide;
  logic [15:0] div_wr;
  logic [15:0] seed_wr;
  logic [7:0]  rd_data;

  logic wr;
  logic rd;
  logic restart;
  logic due;
  logic prompt;
  logic wrap;

  assign div_wide  = 16'(div);
  assign seed_wide = 16'(seed);

  assign wr      = cs & we;
  assign rd      = cs & oe;
  assign restart = wr && (addr_in == ADDR_CTRL) && data_in[CTRL_RESTART];
  // Using >= lets a lowered DIV take effect immediately instead of wrapping the counter
  assign due     = enable && (div_ctr >= div);

  // Merge the addressed write byte into the current DIV/SEED values
  always_comb begin
    div_wr  = div_wide;
    seed_wr = seed_wide;
    case (addr_in)
      ADDR_DIV_LO:  div_wr[7:0]   = data_in;
      ADDR_DIV_HI:  div_wr[15:8]  = data_in;
      ADDR_SEED_LO: seed_wr[7:0]  = data_in;
      ADDR_SEED_HI: seed_wr[15:8] = data_in;
      default: ;
    endcase
  end

  // Read mux; restart is self-clearing so CTRL only reports enable
  always_comb begin
    rd_data = 8'h00;
    case (addr_in)
      ADDR_DIV_LO:  rd_data = div_wide[7:0];
      ADDR_DIV_HI:  rd_data = div_wide[15:8];
      ADDR_SEED_LO: rd_data = seed_wide[7:0];
      ADDR_SEED_HI: rd_data = seed_wide[15:8];
      ADDR_CTRL:    rd_data[CTRL_ENABLE]   = enable;
      ADDR_STATUS:  rd_data[STATUS_ENABLE] = enable;
      default: ;
    endcase
  end

  // Register bus: writes land on the cs&we edge, read data and ack follow one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= DIV_W'(DIV_RST);
      seed     <= '1;
      enable   <= 1'b0;
      data_out <= 8'h00;
      rdy      <= 1'b0;
    end else begin
      rdy <= cs & (we | oe);
      if (rd) begin
        data_out <= rd_data;
      end
      if (wr) begin
        div  <= DIV_W'(div_wr);
        seed <= LFSR_W'(seed_wr);
        if (addr_in == ADDR_CTRL) begin
          enable <= data_in[CTRL_ENABLE];
        end
      end
    end
  end

  // Chip timing and code history; restart overrides a strobe due on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ctr  <= '0;
      hist     <= '0;
      chip_stb <= 1'b0;
      epoch    <= 1'b0;
    end else if (restart) begin
      div_ctr  <= '0;
      hist     <= '0;
      chip_stb <= 1'b0;
      epoch    <= 1'b0;
    end else if (due) begin
      div_ctr  <= '0;
      hist     <= NUM_CH'({hist, prompt});
      chip_stb <= 1'b1;
      epoch    <= wrap;
    end else begin
      chip_stb <= 1'b0;
      epoch    <= 1'b0;
      if (enable) begin
        div_ctr <= div_ctr + DIV_W'(1);
      end
    end
  end

  assign code = hist;

  pn_lfsr #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst),
    .load    (restart),
    .advance (due & ~restart),
    .seed    (seed),
    .prompt  (prompt),
    .wrap    (wrap)
  );

endmodule

// File: tb/tb_pn_code_gen.sv
// tb/tb_pn_code_gen.sv - scoreboard testbench for pn_code_gen
module tb_pn_code_gen;

  localparam logic [9:0] TAPS     = 10'h240;
  localparam logic [7:0] A_DIV_LO  = 8'h00;
  localparam logic [7:0] A_DIV_HI  = 8'h01;
  localparam logic [7:0] A_SEED_LO = 8'h02;
  localparam logic [7:0] A_SEED_HI = 8'h03;
  localparam logic [7:0] A_CTRL    = 8'h04;
  localparam logic [7:0] A_STATUS  = 8'h05;
  localparam logic [7:0] A_NONE    = 8'h07;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_in;
  logic [7:0] data_in;
  logic       cs;
  logic       we;
  logic       oe;
  logic [7:0] data_out;
  logic       rdy;
  logic [1:0] code;
  logic       chip_stb;
  logic       epoch;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic chip;
    logic ep;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  m_lfsr;
  logic [9:0]  m_start;
  logic [1:0]  last_code;
  logic [10:0] first_bits;
  int          first_ep_idx;
  int          sb_count;

  pn_code_gen #(
    .LFSR_W  (10),
    .TAPS    (10'h240),
    .DIV_W   (16),
    .DIV_RST (3),
    .NUM_CH  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .data_out (data_out),
    .rdy      (rdy),
    .code     (code),
    .chip_stb (chip_stb),
    .epoch    (epoch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_in = a; data_in = d; cs = 1'b1; we = 1'b1;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr_in = a; cs = 1'b1; oe = 1'b1;
    step();
    cs = 1'b0; oe = 1'b0;
    d = data_out;
  endtask

  // Reference sequence: expected prompt chip and epoch flag for the next n strobes after a restart
  task automatic sb_restart(input logic [9:0] seed, input int n);
    logic [9:0] nxt;
    exp_t e;
    m_lfsr  = (seed == 10'h000) ? 10'h3FF : seed;
    m_start = m_lfsr;
    sb.delete();
    last_code    = 2'b00;
    first_bits   = '0;
    first_ep_idx = -1;
    sb_count     = 0;
    for (int i = 0; i < n; i++) begin
      e.chip = m_lfsr[9];
      nxt    = {m_lfsr[8:0], ^(m_lfsr & TAPS)};
      e.ep   = (nxt == m_start);
      m_lfsr = nxt;
      sb.push_back(e);
    end
  endtask

  task automatic drain_sb(input string name, input int n, input int first_gap, input int period, input int budget);
    int start, last, got, prev_ep, gap, want_gap;
    exp_t e;
    start = cyc; last = cyc; got = 0; prev_ep = -1;
    while (got < n && (cyc - start) < budget) begin
      step();
      if (chip_stb === 1'b1) begin
        e = '0;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s_sb_empty strobe %0d has no expected entry", name, got);
        end else begin
          e = sb.pop_front();
        end
        sb_count++;
        gap = cyc - last;
        want_gap = (got == 0) ? first_gap : period;
        n_tests++;
        if (gap !== want_gap) begin
          n_fail++; $display("FAIL %s_gap strobe %0d got %0d exp %0d", name, got, gap, want_gap);
        end
        n_tests++;
        if (code[0] !== e.chip) begin
          n_fail++; $display("FAIL %s_chip strobe %0d got %b exp %b", name, got, code[0], e.chip);
        end
        n_tests++;
        if (epoch !== e.ep) begin
          n_fail++; $display("FAIL %s_epoch strobe %0d got %b exp %b", name, got, epoch, e.ep);
        end
        n_tests++;
        if (code[1] !== last_code[0]) begin
          n_fail++; $display("FAIL %s_delay strobe %0d got %b exp %b", name, got, code[1], last_code[0]);
        end
        if (epoch === 1'b1) begin
          if (first_ep_idx < 0) first_ep_idx = sb_count;
          if (prev_ep >= 0) begin
            n_tests++;
            if ((cyc - prev_ep) !== period * 1023) begin
              n_fail++; $display("FAIL %s_epoch_period got %0d exp %0d", name, cyc - prev_ep, period * 1023);
            end
          end
          prev_ep = cyc;
        end
        if (sb_count <= 11) first_bits = {first_bits[9:0], code[0]};
        last_code = code;
        last = cyc;
        got++;
      end else begin
        n_tests++;
        if (epoch !== 1'b0) begin
          n_fail++; $display("FAIL %s_epoch_idle got %b exp 0", name, epoch);
        end
        n_tests++;
        if (code !== last_code) begin
          n_fail++; $display("FAIL %s_hold got %b exp %b", name, code, last_code);
        end
      end
    end
    if (got < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout got %0d strobes exp %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; addr_in = 8'h00; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (code !== 2'b00) begin n_fail++; $display("FAIL reset_code got %b exp 00", code); end
    n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b exp 0", chip_stb); end
    n_tests++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL reset_epoch got %b exp 0", epoch); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", data_out); end
    rst = 1'b1;
    bus_read(A_STATUS, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h exp 00", d); end
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_pulse got %b exp 1", rdy); end
    step();
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_single got %b exp 0", rdy); end
    bus_read(A_DIV_LO, d);
    n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL reset_div got %h exp 03", d); end
  endtask

  task automatic test_div0();
    bus_write(A_DIV_LO, 8'h00);
    bus_write(A_DIV_HI, 8'h00);
    bus_write(A_SEED_LO, 8'hFF);
    bus_write(A_SEED_HI, 8'h03);
    sb_restart(10'h3FF, 2100);
    bus_write(A_CTRL, 8'h03);
    n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL div0_restart_stb got %b exp 0", chip_stb); end
    n_tests++; if (code !== 2'b00) begin n_fail++; $display("FAIL div0_restart_code got %b exp 00", code); end
    drain_sb("div0", 2047, 1, 1, 2300);
    n_tests++; if (first_bits !== 11'b11111111110) begin n_fail++; $display("FAIL div0_first_chips got %b exp 11111111110", first_bits); end
    n_tests++; if (first_ep_idx !== 1023) begin n_fail++; $display("FAIL div0_epoch_idx got %0d exp 1023", first_ep_idx); end
  endtask

  task automatic test_div3();
    bus_write(A_DIV_LO, 8'h03);
    sb_restart(10'h3FF, 2100);
    bus_write(A_CTRL, 8'h03);
    drain_sb("div3", 2047, 4, 4, 8500);
    n_tests++; if (first_ep_idx !== 1023) begin n_fail++; $display("FAIL div3_epoch_idx got %0d exp 1023", first_ep_idx); end
  endtask

  task automatic test_seed_zero();
    logic [7:0] d;
    bus_write(A_SEED_LO, 8'h00);
    bus_write(A_SEED_HI, 8'h00);
    bus_read(A_SEED_LO, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL seed0_lo got %h exp 00", d); end
    bus_read(A_SEED_HI, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL seed0_hi got %h exp 00", d); end
    bus_write(A_DIV_LO, 8'h00);
    sb_restart(10'h000, 1100);
    bus_write(A_CTRL, 8'h03);
    drain_sb("seed0", 1100, 1, 1, 1300);
    n_tests++; if (first_bits !== 11'b11111111110) begin n_fail++; $display("FAIL seed0_first_chips got %b exp 11111111110", first_bits); end
    n_tests++; if (first_ep_idx !== 1023) begin n_fail++; $display("FAIL seed0_epoch_idx got %0d exp 1023", first_ep_idx); end
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL ctrl_read got %h exp 01", d); end
    bus_read(A_STATUS, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL status_read got %h exp 01", d); end
    bus_write(A_NONE, 8'hFF);
    bus_read(A_NONE, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got %h exp 00", d); end
  endtask

  task automatic test_restart_collision();
    int k;
    bus_write(A_SEED_LO, 8'h55);
    bus_write(A_SEED_HI, 8'h01);
    bus_write(A_DIV_LO, 8'h03);
    k = 0;
    while (chip_stb !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_tests++; if (chip_stb !== 1'b1) begin n_fail++; $display("FAIL coll_sync got %b exp 1", chip_stb); end
    repeat (3) step();
    sb_restart(10'h155, 40);
    bus_write(A_CTRL, 8'h03);
    n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL coll_stb got %b exp 0", chip_stb); end
    n_tests++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL coll_epoch got %b exp 0", epoch); end
    n_tests++; if (code !== 2'b00) begin n_fail++; $display("FAIL coll_code got %b exp 00", code); end
    drain_sb("coll", 40, 4, 4, 200);
  endtask

  task automatic test_div_change_and_freeze();
    logic [1:0] frozen;
    bus_write(A_DIV_LO, 8'h00);
    bus_write(A_DIV_HI, 8'h01);
    sb_restart(10'h155, 60);
    bus_write(A_CTRL, 8'h03);
    repeat (8'h7F) step();
    bus_write(A_DIV_LO, 8'h10);
    bus_write(A_DIV_HI, 8'h00);
    drain_sb("divchg", 30, 1, 17, 700);
    bus_write(A_CTRL, 8'h00);
    frozen = code;
    for (int i = 0; i < 50; i++) begin
      step();
      n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL freeze_stb cycle %0d got %b exp 0", i, chip_stb); end
      n_tests++; if (code !== frozen) begin n_fail++; $display("FAIL freeze_code cycle %0d got %b exp %b", i, code, frozen); end
    end
    bus_write(A_CTRL, 8'h01);
    drain_sb("resume", 20, 16, 17, 400);
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    bus_write(A_DIV_LO, 8'h00);
    repeat (2) step();
    bus_read(A_STATUS, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL midrun_pre_status got %h exp 01", d); end
    n_tests++; if (chip_stb !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_stb got %b exp 1", chip_stb); end
    #3;
    rst = 1'b0;
    #1;
    n_tests++; if (code !== 2'b00) begin n_fail++; $display("FAIL midrun_code got %b exp 00", code); end
    n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL midrun_stb got %b exp 0", chip_stb); end
    n_tests++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL midrun_epoch got %b exp 0", epoch); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL midrun_rdy got %b exp 0", rdy); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrun_data got %h exp 00", data_out); end
    step();
    rst = 1'b1;
    bus_read(A_STATUS, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrun_status got %h exp 00", d); end
    bus_read(A_DIV_LO, d);
    n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL midrun_div got %h exp 03", d); end
    repeat (2) step();
    n_tests++; if (chip_stb !== 1'b0) begin n_fail++; $display("FAIL midrun_idle_stb got %b exp 0", chip_stb); end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_div3();
    test_seed_zero();
    test_restart_collision();
    test_div_change_and_freeze();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
